axi_lite_cmd_master: RTL and testbench
======================================

// Module: axi_lite_cmd_master
// PURPOSE
//  Upstream AXI-Lite master for the configure-register slave. Turns a simple command stream
//  (write/read, addr, data) into single AXI-Lite transactions and returns each result on a response stream.
//  Absorbs the extra interrupt B beats (bresp=2'b01) that the slave emits after interrupt-enabled accesses,
//  and reports each one as a one-cycle interrupt event.
//  Sits between a host-side command source (UART/JTAG decoder, init sequencer) and the slave's axil port.
// PARAMETERS
//  ASIZE    32    address width
//  DSIZE    32    data width
//  TIMEOUT  1024  cycles allowed per AXI phase before abort (used only with AXIL_CMD_TIMEOUT_EN)
// PORTS
//  clock        in   1      single clock; every register samples on its rising edge
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when cmd_valid&&cmd_ready
//  cmd_write    in   1      1=write, 0=read
//  cmd_addr     in   ASIZE  target register address
//  cmd_wdata    in   DSIZE  write data (ignored for reads)
//  rsp_valid    out  1      result present
//  rsp_ready    in   1      result consumed
//  rsp_write    out  1      echo of cmd_write
//  rsp_resp     out  2      bresp for writes; 2'b00 for reads; 2'b10 on timeout
//  rsp_rdata    out  DSIZE  read data; 0 for writes
//  intr_valid   out  1      one-cycle pulse per absorbed interrupt B beat
//  intr_addr    out  ASIZE  address of the last completed command
//  axi_awvalid/axi_awready/axi_awaddr[ASIZE]   out/in/out  AW channel
//  axi_wvalid/axi_wready/axi_wdata[DSIZE]      out/in/out  W channel
//  axi_bvalid/axi_bready/axi_bresp[2]          in/out/in   B channel
//  axi_arvalid/axi_arready/axi_araddr[ASIZE]   out/in/out  AR channel
//  axi_rvalid/axi_rready/axi_rdata[DSIZE]      in/out/in   R channel
// BEHAVIOUR
//  Reset: state=IDLE. While rst=1, all of these are 0: cmd_ready, every AXI valid/ready, rsp_*, intr_*, and the
//   captured addr/data. Reset mid-transaction aborts immediately; outstanding beats are dropped.
//  FSM states: IDLE, W_REQ, W_RESP, R_REQ, R_DATA, RSP.
//  IDLE: cmd_ready=1 (combinational: state==IDLE && !rst). On accept, capture cmd_*.
//   Next state is W_REQ if cmd_write=1, else R_REQ.
//  W_REQ: axi_awvalid and axi_wvalid rise together on the cycle after accept.
//   Each is held until its own handshake, then dropped independently (aw_done / w_done flags).
//   Any arrival order is legal, including same-cycle handshakes. When aw_done&&w_done -> W_RESP.
//  W_RESP: the first B beat is the response. Capture bresp -> RSP.
//  R_REQ: axi_arvalid held until axi_arready -> R_DATA.
//  R_DATA: axi_rready=1. On axi_rvalid, capture rdata -> RSP.
//  RSP: rsp_valid=1, with stable rsp_* and intr_addr<=captured addr. On rsp_ready -> IDLE.
//  Latency: minimum accept-to-rsp_valid is 3 cycles for both reads and writes with a zero-wait slave.
//  axi_bready=1 in every state outside reset.
//  A B beat outside W_RESP with bresp=2'b01 -> intr_valid=1 for exactly one cycle.
//  A B beat outside W_RESP with any other bresp is dropped silently.
//  An interrupt beat arriving in the same cycle as rsp_ready is still reported, and intr_addr is updated first.
//  A new command stalls in W_REQ/R_REQ while the slave waits in its interrupt state. This is legal; no deadlock,
//   because bready stays high.
//  Only one transaction is in flight at a time; there is no pipelining across commands.
// CONFIGURATION
//  AXIL_CMD_TIMEOUT_EN defined:
//   - A per-phase cycle counter resets on each state entry and counts in W_REQ, W_RESP, R_REQ and R_DATA.
//   - When it reaches TIMEOUT, all AXI valids drop the next cycle, rsp_resp=2'b10, rsp_rdata=0, and the FSM goes to RSP.
//  AXIL_CMD_TIMEOUT_EN undefined:
//   - No counter; the FSM waits indefinitely.
//   - TIMEOUT is unused and rsp_resp never equals 2'b10.
// TESTING
//  T1 write 0x0000_0010<=0xDEAD_BEEF, slave zero-wait -> one AW+W beat, rsp_valid 3 cycles after accept, rsp_resp=00.
//  T2 read 0x10 after T1 -> rsp_rdata=0xDEAD_BEEF, rsp_write=0, rsp_resp=00; rready high only in R_DATA.
//  T3 write with awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5; one rsp.
//  T4 interrupt-enabled addr 0x20 write, trigger 10 cycles later -> rsp first, then intr_valid 1 cycle, intr_addr=0x20.
//  T5 rsp_ready held low 8 cycles -> rsp_* stable; cmd_ready=0 throughout; rst pulse in R_REQ -> arvalid=0 next cycle.
//  T6 (AXIL_CMD_TIMEOUT_EN, TIMEOUT=16) arready tied 0 -> arvalid drops after 16 cycles, rsp_resp=2'b10.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
//
// Purpose
//   Upstream AXI-Lite master for the configure-register slave. Each accepted
//   command (write/read, addr, data) becomes exactly one AXI-Lite transaction.
//   Its result comes back on the response stream. Only one transaction is in
//   flight at a time.
//   Extra B beats that the slave emits after interrupt-enabled accesses
//   (bresp = 2'b01) are absorbed. Each one is reported as a one-cycle
//   interrupt event tagged with the address of the last completed command.
//
// Parameters
//   ASIZE    address width
//   DSIZE    data width
//   TIMEOUT  cycles allowed per AXI phase before abort. Only used when
//            AXIL_CMD_TIMEOUT_EN is defined.
//
// Configuration macro
//   AXIL_CMD_TIMEOUT_EN : when defined, a per-phase cycle counter aborts a
//                         stuck phase after TIMEOUT cycles. The aborted
//                         command completes with rsp_resp = 2'b10 and
//                         rsp_rdata = 0. When undefined, the FSM waits
//                         indefinitely.
//
// Ports
//   clock, rst                 clock and synchronous active-high reset
//   cmd_valid/ready            command handshake
//   cmd_write/addr/wdata       command payload
//   rsp_valid/ready            response handshake
//   rsp_write/resp/rdata       response payload
//   intr_valid                 one-cycle pulse per absorbed interrupt B beat
//   intr_addr                  address of the last completed command
//   axi_aw*, axi_w*, axi_b*,
//   axi_ar*, axi_r*            AXI-Lite master channels
// ---------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int ASIZE   = 32,
    parameter int DSIZE   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [ASIZE-1:0] cmd_addr,
    input  logic [DSIZE-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [1:0]       rsp_resp,
    output logic [DSIZE-1:0] rsp_rdata,
    output logic             intr_valid,
    output logic [ASIZE-1:0] intr_addr,
    output logic             axi_awvalid,
    input  logic             axi_awready,
    output logic [ASIZE-1:0] axi_awaddr,
    output logic             axi_wvalid,
    input  logic             axi_wready,
    output logic [DSIZE-1:0] axi_wdata,
    input  logic             axi_bvalid,
    output logic             axi_bready,
    input  logic [1:0]       axi_bresp,
    output logic             axi_arvalid,
    input  logic             axi_arready,
    output logic [ASIZE-1:0] axi_araddr,
    input  logic             axi_rvalid,
    output logic             axi_rready,
    input  logic [DSIZE-1:0] axi_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_REQ  = 3'd1,
        W_RESP = 3'd2,
        R_REQ  = 3'd3,
        R_DATA = 3'd4,
        RSP    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_INTR    = 2'b01;
    localparam logic [1:0] RESP_TIMEOUT = 2'b10;

    state_t             state_r;
    state_t             state_s;
    logic               write_r;
    logic [ASIZE-1:0]   addr_r;
    logic [DSIZE-1:0]   wdata_r;
    logic               aw_done_r;
    logic               w_done_r;
    logic [1:0]         rsp_resp_r;
    logic [DSIZE-1:0]   rsp_rdata_r;
    logic               intr_valid_r;
    logic [ASIZE-1:0]   intr_addr_r;

    logic               live_s;
    logic               accept_s;
    logic               aw_hs_s;
    logic               w_hs_s;
    logic               b_hs_s;
    logic               ar_hs_s;
    logic               r_hs_s;
    logic               rsp_hs_s;
    logic               aw_done_now_s;
    logic               w_done_now_s;
    logic               intr_beat_s;
    logic               timeout_s;
    logic               to_rsp_timeout_s;

    // Every output is forced low while rst is high, not just from the next edge.
    assign live_s        = ~rst;

    assign cmd_ready     = live_s & (state_r == IDLE);
    assign axi_awvalid   = live_s & (state_r == W_REQ) & ~aw_done_r;
    assign axi_wvalid    = live_s & (state_r == W_REQ) & ~w_done_r;
    assign axi_awaddr    = live_s ? addr_r  : {ASIZE{1'b0}};
    assign axi_wdata     = live_s ? wdata_r : {DSIZE{1'b0}};
    assign axi_bready    = live_s;
    assign axi_arvalid   = live_s & (state_r == R_REQ);
    assign axi_araddr    = live_s ? addr_r  : {ASIZE{1'b0}};
    assign axi_rready    = live_s & (state_r == R_DATA);

    assign rsp_valid     = live_s & (state_r == RSP);
    assign rsp_write     = live_s & write_r;
    assign rsp_resp      = live_s ? rsp_resp_r  : 2'b00;
    assign rsp_rdata     = live_s ? rsp_rdata_r : {DSIZE{1'b0}};
    assign intr_valid    = live_s & intr_valid_r;
    assign intr_addr     = live_s ? intr_addr_r : {ASIZE{1'b0}};

    assign accept_s      = cmd_valid & cmd_ready;
    assign aw_hs_s       = axi_awvalid & axi_awready;
    assign w_hs_s        = axi_wvalid & axi_wready;
    assign b_hs_s        = axi_bvalid & axi_bready;
    assign ar_hs_s       = axi_arvalid & axi_arready;
    assign r_hs_s        = axi_rvalid & axi_rready;
    assign rsp_hs_s      = rsp_valid & rsp_ready;

    // AW and W complete independently; a handshake this cycle counts as done.
    assign aw_done_now_s = aw_done_r | aw_hs_s;
    assign w_done_now_s  = w_done_r | w_hs_s;

    // Any B beat outside W_RESP is not a response: report it if it is an interrupt.
    assign intr_beat_s   = b_hs_s & (state_r != W_RESP) & (axi_bresp == RESP_INTR);

`ifdef AXIL_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] phase_cnt_r;
    logic          counting_s;

    assign counting_s = (state_r == W_REQ) | (state_r == W_RESP) |
                        (state_r == R_REQ) | (state_r == R_DATA);

    // The phase runs out on its TIMEOUT-th cycle, so valids are held exactly TIMEOUT cycles.
    assign timeout_s  = counting_s & (phase_cnt_r == CW'(TIMEOUT - 1));

    // Per-phase cycle counter, restarted whenever the FSM changes state.
    always_ff @(posedge clock) begin
        if (rst) begin
            phase_cnt_r <= {CW{1'b0}};
        end else if (state_s != state_r) begin
            phase_cnt_r <= {CW{1'b0}};
        end else if (counting_s) begin
            phase_cnt_r <= phase_cnt_r + CW'(1'b1);
        end else begin
            phase_cnt_r <= {CW{1'b0}};
        end
    end
`else
    logic [31:0] timeout_unused_s;

    assign timeout_unused_s = 32'(TIMEOUT);
    assign timeout_s        = 1'b0;
`endif

    // Next-state logic. A handshake that lands on the timeout cycle wins over the abort.
    always_comb begin
        state_s          = state_r;
        to_rsp_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = cmd_write ? W_REQ : R_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            W_REQ: begin
                if (aw_done_now_s && w_done_now_s) begin
                    state_s = W_RESP;
                end else if (timeout_s) begin
                    state_s          = RSP;
                    to_rsp_timeout_s = 1'b1;
                end else begin
                    state_s = W_REQ;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    state_s = RSP;
                end else if (timeout_s) begin
                    state_s          = RSP;
                    to_rsp_timeout_s = 1'b1;
                end else begin
                    state_s = W_RESP;
                end
            end
            R_REQ: begin
                if (ar_hs_s) begin
                    state_s = R_DATA;
                end else if (timeout_s) begin
                    state_s          = RSP;
                    to_rsp_timeout_s = 1'b1;
                end else begin
                    state_s = R_REQ;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    state_s = RSP;
                end else if (timeout_s) begin
                    state_s          = RSP;
                    to_rsp_timeout_s = 1'b1;
                end else begin
                    state_s = R_DATA;
                end
            end
            RSP: begin
                if (rsp_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, command capture, channel-done flags and response capture.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= IDLE;
            write_r     <= 1'b0;
            addr_r      <= {ASIZE{1'b0}};
            wdata_r     <= {DSIZE{1'b0}};
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            rsp_resp_r  <= 2'b00;
            rsp_rdata_r <= {DSIZE{1'b0}};
        end else begin
            state_r <= state_s;

            if (accept_s) begin
                write_r   <= cmd_write;
                addr_r    <= cmd_addr;
                wdata_r   <= cmd_wdata;
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end else if (state_r == W_REQ) begin
                aw_done_r <= aw_done_now_s;
                w_done_r  <= w_done_now_s;
            end

            if ((state_r == W_RESP) && b_hs_s) begin
                rsp_resp_r  <= axi_bresp;
                rsp_rdata_r <= {DSIZE{1'b0}};
            end else if ((state_r == R_DATA) && r_hs_s) begin
                rsp_resp_r  <= RESP_OKAY;
                rsp_rdata_r <= axi_rdata;
            end else if (to_rsp_timeout_s) begin
                rsp_resp_r  <= RESP_TIMEOUT;
                rsp_rdata_r <= {DSIZE{1'b0}};
            end
        end
    end

    // Interrupt pulse and its address tag. Both update on the same edge, so the
    // tag is already current when the pulse is seen, even on the rsp_ready cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            intr_valid_r <= 1'b0;
            intr_addr_r  <= {ASIZE{1'b0}};
        end else begin
            intr_valid_r <= intr_beat_s;
            if (state_r == RSP) begin
                intr_addr_r <= addr_r;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
module tb_axi_lite_cmd_master;

`ifdef AXIL_CMD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clock = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic        intr_valid;
    logic [31:0] intr_addr;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [31:0] axi_awaddr, axi_wdata;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [31:0] axi_araddr, axi_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axi_lite_cmd_master #(.ASIZE(32), .DSIZE(32), .TIMEOUT(TO)) dut (
        .clock(clock), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .intr_valid(intr_valid), .intr_addr(intr_addr),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata)
    );

    // ---------------- slave model: per-channel ready delays, small memory ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got;
    logic [31:0] s_addr, s_data;
    logic [31:0] mem [0:63];
    logic        inj = 1'b0;
    logic [1:0]  inj_resp = 2'b00;

    assign axi_awready = axi_awvalid && (aw_cnt >= aw_delay);
    assign axi_wready  = axi_wvalid  && (w_cnt  >= w_delay);
    assign axi_arready = axi_arvalid && (ar_cnt >= ar_delay);

    always @(posedge clock) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            s_addr <= 32'h0; s_data <= 32'h0;
            axi_bvalid <= 1'b0; axi_bresp <= 2'b00;
            axi_rvalid <= 1'b0; axi_rdata <= 32'h0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else begin
            aw_cnt <= (axi_awvalid && !axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi_wvalid  && !axi_wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (axi_arvalid && !axi_arready) ? ar_cnt + 1 : 0;
            if (axi_awvalid && axi_awready) begin aw_got <= 1'b1; s_addr <= axi_awaddr; end
            if (axi_wvalid && axi_wready)   begin w_got  <= 1'b1; s_data <= axi_wdata;  end
            if ((aw_got || (axi_awvalid && axi_awready)) && (w_got || (axi_wvalid && axi_wready))) begin
                mem[aw_got ? s_addr[7:2] : axi_awaddr[7:2]] <= w_got ? s_data : axi_wdata;
                aw_got <= 1'b0; w_got <= 1'b0;
                axi_bvalid <= 1'b1; axi_bresp <= 2'b00;
            end else if (inj) begin
                axi_bvalid <= 1'b1; axi_bresp <= inj_resp;
            end else if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
            end
            if (axi_arvalid && axi_arready) begin
                axi_rvalid <= 1'b1; axi_rdata <= mem[axi_araddr[7:2]];
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          awd, wd, ard;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_aw, exp_w, exp_ar, exp_rr;
    } vec_t;

    // Issue one command with rsp_ready high; measure latency and per-channel valid cycles.
    task automatic run_vec(input vec_t v, input string nm);
        int  lat = 0, n_aw = 0, n_w = 0, n_ar = 0, n_rr = 0, n_cr = 0, n_in = 0;
        bit  seen = 1'b0;
        aw_delay = v.awd; w_delay = v.wd; ar_delay = v.ard;
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clock);
        chk({nm, "_accept"}, 64'(cmd_ready), 64'(1));
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clock);
            if (k == 1) cmd_valid = 1'b0;
            if (axi_awvalid) n_aw++;
            if (axi_wvalid)  n_w++;
            if (axi_arvalid) n_ar++;
            if (axi_rready)  n_rr++;
            if (cmd_ready)   n_cr++;
            if (intr_valid)  n_in++;
            if (rsp_valid) begin seen = 1'b1; lat = k; end
        end
        chk({nm, "_lat"},   64'(lat),       64'(v.exp_lat));
        chk({nm, "_write"}, 64'(rsp_write), 64'(v.wr));
        chk({nm, "_resp"},  64'(rsp_resp),  64'(v.exp_resp));
        chk({nm, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        chk({nm, "_awcyc"}, 64'(n_aw),      64'(v.exp_aw));
        chk({nm, "_wcyc"},  64'(n_w),       64'(v.exp_w));
        chk({nm, "_arcyc"}, 64'(n_ar),      64'(v.exp_ar));
        chk({nm, "_rrcyc"}, 64'(n_rr),      64'(v.exp_rr));
        chk({nm, "_busy_cmd_ready"}, 64'(n_cr), 64'(0));
        chk({nm, "_no_intr"},        64'(n_in), 64'(0));
        @(negedge clock);
        chk({nm, "_rsp_done"}, 64'(rsp_valid), 64'(0));
    endtask

    // Pulse one extra B beat from the slave; return pulses seen and the last tag.
    task automatic inject_beat(input logic [1:0] resp, output int n, output logic [31:0] a);
        n = 0; a = 32'h0;
        inj_resp = resp; inj = 1'b1;
        @(negedge clock);
        inj = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (intr_valid) begin n++; a = intr_addr; end
        end
    endtask

    vec_t vecs [9];

    initial begin
        int          n;
        logic [31:0] a;
        bit          got;
        vec_t        v;

        //            wr    addr          wdata         awd wd ard resp   rdata         lat aw w ar rr
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 32'h0,         3, 1, 1, 0, 0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 0, 0, 2'b00, 32'hDEAD_BEEF, 3, 0, 0, 1, 1};
        vecs[2] = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4, 0, 0, 2'b00, 32'h0,         7, 5, 1, 0, 0};
        vecs[3] = '{1'b0, 32'h0000_0014, 32'h0,         0, 0, 2, 2'b00, 32'h1234_5678, 5, 0, 0, 3, 1};
        vecs[4] = '{1'b1, 32'h0000_0018, 32'hA5A5_0F0F, 0, 3, 0, 2'b00, 32'h0,         6, 1, 4, 0, 0};
        vecs[5] = '{1'b0, 32'h0000_0018, 32'h0,         0, 0, 0, 2'b00, 32'hA5A5_0F0F, 3, 0, 0, 1, 1};
        vecs[6] = '{1'b1, 32'h0000_0010, 32'h0000_0001, 2, 2, 0, 2'b00, 32'h0,         5, 3, 3, 0, 0};
        vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         0, 0, 0, 2'b00, 32'h0000_0001, 3, 0, 0, 1, 1};
        vecs[8] = '{1'b0, 32'h0000_0024, 32'h0,         0, 0, 0, 2'b00, 32'h0,         3, 0, 0, 1, 1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_ctrl", 64'({cmd_ready, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid,
                               axi_rready, rsp_valid, intr_valid}), 64'(8'h00));
        chk("reset_data", 64'({rsp_write, rsp_resp, rsp_rdata, intr_addr}), 64'(0));
        rst = 1'b0;
        @(negedge clock);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("idle_bready",    64'(axi_bready), 64'(1));

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Interrupt-enabled write, trigger 10 cycles later.
        v = '{1'b1, 32'h0000_0020, 32'h0000_00FF, 0, 0, 0, 2'b00, 32'h0, 3, 1, 1, 0, 0};
        run_vec(v, "intr_wr");
        repeat (10) @(negedge clock);
        inject_beat(2'b01, n, a);
        chk("intr_pulses", 64'(n), 64'(1));
        chk("intr_addr",   64'(a), 64'(32'h0000_0020));
        inject_beat(2'b11, n, a);
        chk("non_intr_beat_dropped", 64'(n), 64'(0));

        // Response held for 8 cycles must stay stable with cmd_ready low.
        ar_delay = 0; cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rsp_valid) got = 1'b1; else @(negedge clock);
        end
        chk("hold_rsp_seen", 64'(got), 64'(1));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("hold_stable_%0d", k),
                64'({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}),
                64'({1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0001}));
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("hold_release", 64'({rsp_valid, cmd_ready}), 64'(2'b01));

        // Interrupt beat in the same cycle as rsp_ready.
        aw_delay = 0; w_delay = 0;
        cmd_write = 1'b1; cmd_addr = 32'h0000_0030; cmd_wdata = 32'h0000_0055;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rsp_valid) got = 1'b1; else @(negedge clock);
        end
        chk("coinc_rsp_seen", 64'(got), 64'(1));
        inj_resp = 2'b01; inj = 1'b1;
        @(negedge clock);
        inj = 1'b0; rsp_ready = 1'b1;
        @(negedge clock);
        chk("coinc_intr", 64'({intr_valid, rsp_valid}), 64'(2'b10));
        chk("coinc_intr_addr", 64'(intr_addr), 64'(32'h0000_0030));

        // Reset pulse while the read is waiting in R_REQ.
        ar_delay = 10; cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("rreq_arvalid", 64'(axi_arvalid), 64'(1));
        rst = 1'b1;
        @(negedge clock);
        chk("rst_mid_abort", 64'({axi_arvalid, cmd_ready, rsp_valid, axi_rready}), 64'(4'b0000));
        rst = 1'b0;
        @(negedge clock);
        chk("rst_mid_idle", 64'({cmd_ready, axi_arvalid}), 64'(2'b10));
        v = '{1'b0, 32'h0000_0010, 32'h0, 0, 0, 0, 2'b00, 32'h0, 3, 0, 0, 1, 1};
        run_vec(v, "post_rst_rd");

`ifdef AXIL_CMD_TIMEOUT_EN
        // arready never comes: arvalid held TIMEOUT cycles, then a timeout response.
        v = '{1'b0, 32'h0000_0040, 32'h0, 0, 0, 1000, 2'b10, 32'h0, TO + 1, 0, 0, TO, 0};
        run_vec(v, "timeout_rd");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
